// File: rtl/wb_pkg.sv
// Shared types and default constants for the pipelined Wishbone master.
// WB_PIPE_MASTER_TIMEOUT_EN adds the ABORT state used by the bus timeout.
package wb_pkg;

   localparam int ADDR_W_DEF  = 32;
   localparam int DATA_W_DEF  = 32;
   localparam int MAX_OUT_DEF = 4;
   localparam int TIMEOUT_DEF = 255;

   typedef enum logic [1:0] {
      IDLE,
      BUSY
`ifdef WB_PIPE_MASTER_TIMEOUT_EN
      , ABORT
`endif
   } state_e;

endpackage

// File: rtl/wb_pipe_master_if.sv
// Core request/response and Wishbone B4 pipelined signals of wb_pipe_master.
// master: the bus master view; slave: the core + Wishbone slave view.
interface wb_pipe_master_if
   import wb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
);
   localparam int SEL_W = DATA_W / 8;

   logic              req_i;
   logic              req_we_i;
   logic [ADDR_W-1:0] req_addr_i;
   logic [DATA_W-1:0] req_wdata_i;
   logic [SEL_W-1:0]  req_sel_i;
   logic              req_ready_o;
   logic              rsp_valid_o;
   logic [DATA_W-1:0] rsp_data_o;
   logic              rsp_err_o;
   logic              timeout_o;
   logic              data_wb_cyc_o;
   logic              data_wb_stb_o;
   logic              data_wb_we_o;
   logic [ADDR_W-1:0] data_wb_adr_o;
   logic [DATA_W-1:0] data_wb_dat_o;
   logic [SEL_W-1:0]  data_wb_sel_o;
   logic              data_wb_stall_i;
   logic              data_wb_ack_i;
   logic              data_wb_err_i;
   logic [DATA_W-1:0] data_wb_dat_i;

   modport master (
      input  req_i, req_we_i, req_addr_i, req_wdata_i, req_sel_i,
      input  data_wb_stall_i, data_wb_ack_i, data_wb_err_i,
      input  data_wb_dat_i,
      output req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o,
      output timeout_o, data_wb_cyc_o, data_wb_stb_o, data_wb_we_o,
      output data_wb_adr_o, data_wb_dat_o, data_wb_sel_o
   );

   modport slave (
      output req_i, req_we_i, req_addr_i, req_wdata_i, req_sel_i,
      output data_wb_stall_i, data_wb_ack_i, data_wb_err_i,
      output data_wb_dat_i,
      input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o,
      input  timeout_o, data_wb_cyc_o, data_wb_stb_o, data_wb_we_o,
      input  data_wb_adr_o, data_wb_dat_o, data_wb_sel_o
   );

endinterface

// File: rtl/wb_bus_watchdog.sv
// Counts consecutive enabled cycles without a kick; expires on the LIMIT-th.
module wb_bus_watchdog
   import wb_pkg::*;
#(
   parameter int LIMIT = TIMEOUT_DEF
)(
   input  logic data_wb_clk_i,
   input  logic data_wb_rst_i,
   input  logic i_enable,
   input  logic i_kick,
   output logic o_expire
);
   localparam int W = $clog2(LIMIT + 1);

   logic [W-1:0] r_timer;

   assign o_expire = i_enable && !i_kick && (r_timer == W'(LIMIT - 1));

   always_ff @(posedge data_wb_clk_i or posedge data_wb_rst_i) begin
      if (data_wb_rst_i) begin
         r_timer <= '0;
      end else if (!i_enable || i_kick || o_expire) begin
         r_timer <= '0;
      end else begin
         r_timer <= r_timer + W'(1);
      end
   end

endmodule

// File: rtl/wb_pipe_master.sv
// Pipelined Wishbone B4 master with bounded outstanding transactions.
// Define WB_PIPE_MASTER_TIMEOUT_EN to add the bus-timeout watchdog and ABORT.
module wb_pipe_master
   import wb_pkg::*;
#(
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int DATA_W      = DATA_W_DEF,
   parameter int MAX_OUT     = MAX_OUT_DEF,
   parameter int TIMEOUT_CYC = TIMEOUT_DEF
)(
   input  logic              data_wb_clk_i,
   input  logic              data_wb_rst_i,
   wb_pipe_master_if.master  bus
);
   localparam int SEL_W = DATA_W / 8;
   localparam int CNT_W = $clog2(MAX_OUT) + 1;

   state_e            r_state, w_state_nxt;
   logic              r_stb, r_we, r_cyc;
   logic [ADDR_W-1:0] r_adr;
   logic [DATA_W-1:0] r_dat;
   logic [SEL_W-1:0]  r_sel;
   logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
   logic              r_rsp_valid, r_rsp_err, r_timeout;
   logic [DATA_W-1:0] r_rsp_data;
   logic [CNT_W:0]    w_used;
   logic              w_ready, w_accept, w_issue, w_done;
   logic              w_expire, w_abort, w_stb_nxt;

`ifdef WB_PIPE_MASTER_TIMEOUT_EN
   wb_bus_watchdog #(.LIMIT(TIMEOUT_CYC)) u_wdog (
      .data_wb_clk_i (data_wb_clk_i),
      .data_wb_rst_i (data_wb_rst_i),
      .i_enable      (r_state == BUSY),
      .i_kick        (w_done),
      .o_expire      (w_expire)
   );
   assign w_abort = (r_state == ABORT);
`else
   assign w_expire = 1'b0;
   assign w_abort  = 1'b0;
`endif

   // A request slot counts the beat still sitting on stb as in flight.
   assign w_used   = {1'b0, r_cnt} + {{CNT_W{1'b0}}, r_stb};
   assign w_ready  = !data_wb_rst_i && !w_abort
                  && (!r_stb || !bus.data_wb_stall_i)
                  && (w_used < (CNT_W+1)'(MAX_OUT));
   assign w_accept = bus.req_i && w_ready;
   assign w_issue  = r_stb && !bus.data_wb_stall_i;
   assign w_done   = (bus.data_wb_ack_i || bus.data_wb_err_i)
                  && (r_cnt != '0);

   always_comb begin
      w_stb_nxt = r_stb;
      w_cnt_nxt = r_cnt + CNT_W'(w_issue) - CNT_W'(w_done);
      if (w_accept)     w_stb_nxt = 1'b1;
      else if (w_issue) w_stb_nxt = 1'b0;
      if (w_expire) begin
         w_stb_nxt = 1'b0;
         w_cnt_nxt = '0;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE: if (w_accept) w_state_nxt = BUSY;
         BUSY: begin
            if (w_expire)
               w_state_nxt = state_e'(2);
            else if (!w_stb_nxt && w_cnt_nxt == '0)
               w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge data_wb_clk_i or posedge data_wb_rst_i) begin
      if (data_wb_rst_i) r_state <= IDLE;
      else               r_state <= w_state_nxt;
   end

   always_ff @(posedge data_wb_clk_i or posedge data_wb_rst_i) begin
      if (data_wb_rst_i) begin
         r_stb       <= 1'b0;
         r_we        <= 1'b0;
         r_cyc       <= 1'b0;
         r_adr       <= '0;
         r_dat       <= '0;
         r_sel       <= '0;
         r_cnt       <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_rsp_data  <= '0;
         r_timeout   <= 1'b0;
      end else begin
         r_stb <= w_stb_nxt;
         r_cnt <= w_cnt_nxt;
         r_cyc <= w_stb_nxt || (w_cnt_nxt != '0);
         if (w_accept) begin
            r_we  <= bus.req_we_i;
            r_adr <= bus.req_addr_i;
            r_dat <= bus.req_wdata_i;
            r_sel <= bus.req_sel_i;
         end
         r_rsp_valid <= w_done || w_expire;
         r_rsp_err   <= w_expire || (w_done && bus.data_wb_err_i);
         r_rsp_data  <= (w_done && !bus.data_wb_err_i)
                      ? bus.data_wb_dat_i : '0;
         r_timeout   <= w_expire;
      end
   end

   assign bus.req_ready_o   = w_ready;
   assign bus.rsp_valid_o   = r_rsp_valid;
   assign bus.rsp_data_o    = r_rsp_data;
   assign bus.rsp_err_o     = r_rsp_err;
   assign bus.timeout_o     = r_timeout;
   assign bus.data_wb_cyc_o = r_cyc;
   assign bus.data_wb_stb_o = r_stb;
   assign bus.data_wb_we_o  = r_we;
   assign bus.data_wb_adr_o = r_adr;
   assign bus.data_wb_dat_o = r_dat;
   assign bus.data_wb_sel_o = r_sel;

endmodule

// File: tb/tb_wb_pipe_master.sv
// Scoreboard bench for wb_pipe_master with a queued pipelined slave model.
// Build with WB_PIPE_MASTER_TIMEOUT_EN to also cover the bus timeout.
module tb_wb_pipe_master;
   import wb_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;

   wb_pipe_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   wb_pipe_master #(
      .ADDR_W(32), .DATA_W(32), .MAX_OUT(4), .TIMEOUT_CYC(8)
   ) dut (
      .data_wb_clk_i (clk),
      .data_wb_rst_i (rst),
      .bus           (bus)
   );

   initial forever #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int stb_hi  = 0;
   int tm_seen = 0;
   logic [32:0] exq[$];
   logic [31:0] pend[$];
   bit slv_en   = 1'b1;
   bit slv_hold = 1'b0;
   logic [31:0] err_addr = 32'hFFFF_FFFF;

   task automatic check(input string nm, input logic [63:0] act,
                        input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Slave: one beat accepted per unstalled stb, answered in issue order.
   initial begin
      logic        iss;
      logic [31:0] ia, a;
      forever begin
         @(negedge clk);
         iss = bus.data_wb_cyc_o && bus.data_wb_stb_o && !bus.data_wb_stall_i;
         ia  = bus.data_wb_adr_o;
         @(posedge clk);
         #1;
         if (slv_en) begin
            bus.data_wb_ack_i = 1'b0;
            bus.data_wb_err_i = 1'b0;
            bus.data_wb_dat_i = '0;
            if (iss && !rst) pend.push_back(ia);
            if (!slv_hold && pend.size() > 0) begin
               a = pend.pop_front();
               if (a == err_addr) bus.data_wb_err_i = 1'b1;
               else               bus.data_wb_ack_i = 1'b1;
               bus.data_wb_dat_i = a ^ 32'hDEAD_0000;
            end
         end
      end
   end

   // Monitor: pops the scoreboard on every response pulse.
   initial begin
      logic [32:0] e;
      forever begin
         @(negedge clk);
         if (bus.data_wb_stb_o) stb_hi++;
         if (bus.timeout_o) tm_seen++;
         if (bus.rsp_valid_o) begin
            if (exq.size() == 0) begin
               check("rsp_unexpected", 64'(bus.rsp_valid_o), 64'd0);
            end else begin
               e = exq.pop_front();
               check("rsp", 64'({bus.rsp_err_o, bus.rsp_data_o}), 64'(e));
            end
         end
      end
   end

   task automatic send(input logic we, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] sel,
                       input logic [31:0] ed, input logic ee,
                       input bit push, output int waits);
      bit ok = 1'b0;
      bus.req_i       = 1'b1;
      bus.req_we_i    = we;
      bus.req_addr_i  = a;
      bus.req_wdata_i = wd;
      bus.req_sel_i   = sel;
      waits = 0;
      for (int k = 0; k < 100 && !ok; k++) begin
         @(negedge clk);
         if (bus.req_ready_o) begin
            ok = 1'b1;
         end else begin
            waits++;
            @(posedge clk);
            #1;
         end
      end
      if (!ok) begin
         check("send_accept", 64'(bus.req_ready_o), 64'd1);
      end else begin
         if (push) exq.push_back({ee, ed});
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_drain(input string nm);
      bit ok = 1'b0;
      for (int k = 0; k < 200 && !ok; k++) begin
         @(negedge clk);
         if (exq.size() == 0 && !bus.data_wb_cyc_o) ok = 1'b1;
      end
      check(nm, 64'(ok), 64'd1);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int w, wsum, busy;
      bit seen;
      logic [31:0] rd_addr [4] = '{32'h100, 32'h104, 32'h108, 32'h10C};
      logic [31:0] rd_exp  [4] = '{32'hDEAD_0100, 32'hDEAD_0104,
                                   32'hDEAD_0108, 32'hDEAD_010C};
      logic [31:0] wr_addr [3] = '{32'h400, 32'h404, 32'h408};
      logic [32:0] wr_exp  [3] = '{{1'b0, 32'hDEAD_0400}, {1'b1, 32'h0},
                                   {1'b0, 32'hDEAD_0408}};

      bus.req_i = 1'b1;  bus.req_we_i = 1'b0;
      bus.req_addr_i = 32'h40;  bus.req_wdata_i = '0;  bus.req_sel_i = 4'hF;
      bus.data_wb_stall_i = 1'b0;  bus.data_wb_ack_i = 1'b0;
      bus.data_wb_err_i = 1'b0;  bus.data_wb_dat_i = '0;

      // Reset with a request pending
      repeat (3) @(negedge clk);
      check("rst_ctrl", 64'({bus.req_ready_o, bus.rsp_valid_o, bus.rsp_err_o,
                             bus.timeout_o, bus.data_wb_cyc_o, bus.data_wb_stb_o,
                             bus.data_wb_we_o, bus.data_wb_sel_o}), 64'd0);
      check("rst_adr", 64'(bus.data_wb_adr_o), 64'd0);
      check("rst_dat", {bus.data_wb_dat_o, bus.rsp_data_o}, 64'd0);
      step();
      rst = 1'b0;
      send(1'b0, 32'h40, 32'h0, 4'hF, 32'hDEAD_0040, 1'b0, 1'b1, w);
      check("rst_first_wait", 64'(w), 64'd0);
      bus.req_i = 1'b0;
      @(negedge clk);
      check("rst_first_stb", {31'd0, bus.data_wb_stb_o, bus.data_wb_adr_o},
            {31'd0, 1'b1, 32'h40});
      wait_drain("rst_drain");

      // Back-to-back reads, zero-wait slave
      step();
      stb_hi = 0;
      wsum = 0;
      for (int i = 0; i < 4; i++) begin
         send(1'b0, rd_addr[i], 32'h0, 4'hF, rd_exp[i], 1'b0, 1'b1, w);
         wsum += w;
      end
      bus.req_i = 1'b0;
      check("b2b_waits", 64'(wsum), 64'd0);
      wait_drain("b2b_drain");
      check("b2b_stb_cycles", 64'(stb_hi), 64'd4);

      // Outstanding limit with ack withheld
      step();
      slv_hold = 1'b1;
      wsum = 0;
      for (int i = 0; i < 4; i++) begin
         send(1'b0, 32'h200 + 32'(4*i), 32'h0, 4'hF,
              32'hDEAD_0200 + 32'(4*i), 1'b0, 1'b1, w);
         wsum += w;
      end
      check("lim_waits", 64'(wsum), 64'd0);
      bus.req_addr_i = 32'h210;
      @(negedge clk);
      check("lim_ready_low", 64'({bus.req_ready_o, bus.data_wb_cyc_o}), 64'b01);
      step();
      bus.req_i = 1'b0;
      slv_hold = 1'b0;
      wait_drain("lim_drain");

      // Stalled write holds the bus fields
      step();
      bus.data_wb_stall_i = 1'b1;
      send(1'b1, 32'h300, 32'hCAFE_F00D, 4'b0110, 32'hDEAD_0300, 1'b0, 1'b1, w);
      bus.req_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("stall_adr", 64'(bus.data_wb_adr_o), 64'h300);
      end
      check("stall_fields", 64'({bus.data_wb_stb_o, bus.data_wb_we_o,
                                 bus.data_wb_sel_o, bus.data_wb_dat_o}),
            64'({1'b1, 1'b1, 4'b0110, 32'hCAFE_F00D}));
      check("stall_ready_low", 64'(bus.req_ready_o), 64'd0);
      step();
      bus.data_wb_stall_i = 1'b0;
      wait_drain("stall_drain");

      // Error on the middle write of three
      step();
      err_addr = 32'h404;
      for (int i = 0; i < 3; i++)
         send(1'b1, wr_addr[i], 32'h5A5A_0000 + 32'(i), 4'hF,
              wr_exp[i][31:0], wr_exp[i][32], 1'b1, w);
      bus.req_i = 1'b0;
      wait_drain("err_cyc_low");
      err_addr = 32'hFFFF_FFFF;

      // Spurious ack while idle
      step();
      slv_en = 1'b0;
      bus.data_wb_ack_i = 1'b1;
      bus.data_wb_dat_i = 32'h1234_5678;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("spur_quiet", 64'({bus.rsp_valid_o, bus.data_wb_cyc_o}), 64'd0);
         step();
      end
      bus.data_wb_ack_i = 1'b0;
      @(negedge clk);
      check("spur_quiet_after", 64'({bus.rsp_valid_o, bus.data_wb_cyc_o}), 64'd0);
      step();
      slv_en = 1'b1;
      send(1'b0, 32'h180, 32'h0, 4'hF, 32'hDEAD_0180, 1'b0, 1'b1, w);
      bus.req_i = 1'b0;
      wait_drain("spur_recover");

      // Reset with two transactions in flight
      step();
      slv_hold = 1'b1;
      send(1'b0, 32'h500, 32'h0, 4'hF, 32'h0, 1'b0, 1'b0, w);
      send(1'b0, 32'h504, 32'h0, 4'hF, 32'h0, 1'b0, 1'b0, w);
      bus.req_i = 1'b0;
      step();
      rst = 1'b1;
      slv_en = 1'b0;
      pend.delete();
      bus.data_wb_ack_i = 1'b0;
      step();
      rst = 1'b0;
      bus.data_wb_ack_i = 1'b1;
      bus.data_wb_dat_i = 32'h0BAD_0500;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("mrst_quiet", 64'({bus.rsp_valid_o, bus.data_wb_cyc_o}), 64'd0);
         step();
      end
      bus.data_wb_ack_i = 1'b0;
      slv_hold = 1'b0;
      slv_en = 1'b1;
      send(1'b0, 32'h600, 32'h0, 4'hF, 32'hDEAD_0600, 1'b0, 1'b1, w);
      bus.req_i = 1'b0;
      wait_drain("mrst_recover");

`ifdef WB_PIPE_MASTER_TIMEOUT_EN
      // Bus timeout after eight silent busy cycles
      step();
      slv_hold = 1'b1;
      send(1'b0, 32'h700, 32'h0, 4'hF, 32'h0, 1'b1, 1'b1, w);
      bus.req_i = 1'b0;
      busy = 0;
      seen = 1'b0;
      for (int k = 0; k < 50 && !seen; k++) begin
         @(negedge clk);
         if (bus.timeout_o) seen = 1'b1;
         else if (bus.data_wb_cyc_o) busy++;
      end
      check("to_seen", 64'(seen), 64'd1);
      check("to_busy_cycles", 64'(busy), 64'd8);
      check("to_cyc_low", 64'({bus.data_wb_cyc_o, bus.data_wb_stb_o}), 64'd0);
      @(negedge clk);
      check("to_pulse_end", 64'({bus.timeout_o, bus.rsp_valid_o}), 64'd0);
      step();
      pend.delete();
      slv_hold = 1'b0;
      send(1'b0, 32'h704, 32'h0, 4'hF, 32'hDEAD_0704, 1'b0, 1'b1, w);
      bus.req_i = 1'b0;
      wait_drain("to_recover");
      check("timeout_count", 64'(tm_seen), 64'd1);
`else
      check("timeout_count", 64'(tm_seen), 64'd0);
`endif

      repeat (3) @(negedge clk);
      check("scoreboard_empty", 64'(exq.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
